// File: rtl/chebyshev_coeff_sequencer.sv
// ============================================================================
// Module   : chebyshev_coeff_sequencer
// Brief    : Coefficient store that streams c[N]..c[0] with the latched sample
//            to a Clenshaw-style evaluator over a valid/ready handshake.
//            Optional macro CHEB_SEQ_HALF_C0_EN halves the c[0] beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chebyshev_coeff_sequencer #(
    parameter int WL   = 4,
    parameter int CL   = 4,
    parameter int NMAX = 8,
    parameter int AW   = 3
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CL-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          start,
    input  logic [WL-1:0] x_in,
    input  logic [AW-1:0] order_in,
    output logic [WL-1:0] data_out,
    output logic [CL-1:0] coeff_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [AW:0]   C_NMAX     = (AW+1)'(NMAX);
    localparam logic [AW-1:0] C_LAST_IDX = AW'(NMAX - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_order;
    logic [WL-1:0] r_x;
    logic [CL-1:0] r_mem [NMAX];
    logic          r_cfg_err;

    logic          w_stream;
    logic          w_accept;
    logic          w_xfer;
    logic          w_addr_ok;
    logic          w_wr_en;
    logic [AW-1:0] w_order_clamped;
    logic [CL-1:0] w_raw;
    logic [CL-1:0] w_coeff;

    assign w_stream        = (r_state == ST_STREAM);
    assign w_accept        = (r_state == ST_IDLE) && start;
    assign w_xfer          = w_stream && out_ready;
    assign w_addr_ok       = ({1'b0, cfg_addr} < C_NMAX);
    assign w_wr_en         = cfg_we && !w_stream && w_addr_ok;
    assign w_order_clamped = ({1'b0, order_in} >= C_NMAX) ? C_LAST_IDX : order_in;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_STREAM;
            ST_STREAM: if (w_xfer && (r_idx == '0)) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_idx   <= '0;
            r_order <= '0;
            r_x     <= '0;
        end else if (w_accept) begin
            r_idx   <= w_order_clamped;
            r_order <= w_order_clamped;
            r_x     <= x_in;
        end else if (w_xfer && (r_idx != '0)) begin
            r_idx   <= r_idx - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NMAX; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[cfg_addr] <= cfg_data;
        end
    end

    // Rejected writes: attempted during a stream, or addressing past the store.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && (w_stream || !w_addr_ok);
        end
    end

    assign w_raw = r_mem[r_idx];

`ifdef CHEB_SEQ_HALF_C0_EN
    // c0/2 term of the series: arithmetic shift keeps the sign.
    assign w_coeff = (r_idx == '0) ? {w_raw[CL-1], w_raw[CL-1:1]} : w_raw;
`else
    assign w_coeff = w_raw;
`endif

    assign out_valid = w_stream;
    assign busy      = w_stream;
    assign done      = (r_state == ST_DONE);
    assign cfg_err   = r_cfg_err;
    assign coeff_out = w_stream ? w_coeff : '0;
    assign data_out  = w_stream ? r_x : '0;
    assign out_first = w_stream && (r_idx == r_order);
    assign out_last  = w_stream && (r_idx == '0);

endmodule

`default_nettype wire

// File: tb/tb_chebyshev_coeff_sequencer.sv
// ============================================================================
// Module   : tb_chebyshev_coeff_sequencer
// Brief    : Directed and randomised bench for chebyshev_coeff_sequencer
//            against an array-based model of the coefficient store.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chebyshev_coeff_sequencer;

    localparam int WL   = 4;
    localparam int CL   = 4;
    localparam int NMAX = 6;
    localparam int AW   = 3;

    logic          clock = 1'b0;
    logic          resetn;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CL-1:0] cfg_data;
    logic          cfg_err;
    logic          start;
    logic [WL-1:0] x_in;
    logic [AW-1:0] order_in;
    logic [WL-1:0] data_out;
    logic [CL-1:0] coeff_out;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
    logic          busy;
    logic          done;

    int errs   = 0;
    int checks = 0;
    logic [CL-1:0] mem_m [NMAX];
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    chebyshev_coeff_sequencer #(.WL(WL), .CL(CL), .NMAX(NMAX), .AW(AW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .start     (start),
        .x_in      (x_in),
        .order_in  (order_in),
        .data_out  (data_out),
        .coeff_out (coeff_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value the stream should carry for c[k]; c[0] is halved (floor) when enabled.
    function automatic logic [CL-1:0] model_coeff(input int k);
        int v;
        v = int'($signed(mem_m[k]));
`ifdef CHEB_SEQ_HALF_C0_EN
        if (k == 0) v = v >>> 1;
`endif
        return CL'(v);
    endfunction

    task automatic wr(input int addr, input logic [CL-1:0] data);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = data;
        @(posedge clock); #1;
        cfg_we = 1'b0;
        chk("wr_err", cfg_err, (addr >= NMAX) ? 1 : 0);
        if (addr < NMAX) mem_m[addr] = data;
    endtask

    // mode 0: ready always high, 1: fixed toggle pattern, 2: random ready.
    task automatic run(input logic [WL-1:0] x, input int order, input int mode,
                       input bit inject, input bit sw_we, input int sw_addr,
                       input logic [CL-1:0] sw_data);
        int n, pos, cyc;
        bit rdy, exp_err;
        logic [CL-1:0] exp_c [$];
        start    = 1'b1;
        x_in     = x;
        order_in = AW'(order);
        cfg_we   = sw_we;
        cfg_addr = AW'(sw_addr);
        cfg_data = sw_data;
        if (sw_we && sw_addr < NMAX) mem_m[sw_addr] = sw_data;
        n = (order > NMAX - 1) ? NMAX - 1 : order;
        exp_c = {};
        for (int k = n; k >= 0; k--) exp_c.push_back(model_coeff(k));
        @(posedge clock); #1;
        start   = 1'b0;
        cfg_we  = 1'b0;
        exp_err = sw_we && (sw_addr >= NMAX);
        pos = 0;
        cyc = 0;
        while (pos <= n && cyc < 200) begin
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("done_in_stream", done, 0);
            chk("coeff", coeff_out, exp_c[pos]);
            chk("data", data_out, x);
            chk("first", out_first, (pos == 0) ? 1 : 0);
            chk("last", out_last, (pos == n) ? 1 : 0);
            chk("cfg_err_stream", cfg_err, exp_err);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc < 7) ? pat[cyc] : 1'b1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            exp_err = 1'b0;
            if (inject && cyc == 1) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'd2;
                cfg_data = 4'b0111;
                start    = 1'b1;
                x_in     = ~x;
                exp_err  = 1'b1;
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                x_in     = WL'($urandom);
                order_in = AW'($urandom);
            end
            @(posedge clock); #1;
            cfg_we = 1'b0;
            start  = 1'b0;
            if (rdy) pos++;
            cyc++;
        end
        if (cyc >= 200) chk("stream_budget", pos, n + 1);
        chk("done_pulse", done, 1);
        chk("valid_in_done", out_valid, 0);
        chk("busy_in_done", busy, 0);
        chk("cfg_err_done", cfg_err, exp_err);
        start     = 1'b1;
        x_in      = WL'($urandom);
        out_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        chk("done_once", done, 0);
        chk("start_in_done_ignored", out_valid, 0);
        @(posedge clock); #1;
        chk("idle_after_done", out_valid, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        start     = 1'b0;
        x_in      = '0;
        order_in  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NMAX; i++) mem_m[i] = '0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_coeff", coeff_out, 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // Readback of a cleared store, order clamped to NMAX-1.
        run(4'b1001, 7, 0, 0, 0, 0, '0);

        wr(0, 4'b0010);
        wr(1, 4'b1100);
        wr(2, 4'b0101);
        wr(3, 4'b0001);
        run(4'b0100, 3, 0, 0, 0, 0, '0);
        run(4'b0100, 3, 1, 0, 0, 0, '0);

        wr(NMAX, 4'b1111);
        wr(7, 4'b1110);

        wr(0, 4'b1011);
        run(4'b0011, 0, 0, 0, 0, 0, '0);
        chk("c0_store_kept", mem_m[0], 4'b1011);

        run(4'b0110, 3, 1, 1, 0, 0, '0);
        run(4'b0110, 3, 0, 0, 0, 0, '0);

        // Write committed alongside start is visible to that run.
        run(4'b1010, 4, 0, 0, 1, 4, 4'b1010);
        run(4'b0001, 5, 0, 0, 1, 6, 4'b0111);

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < 3; w++) wr($urandom_range(0, 7), CL'($urandom));
            run(WL'($urandom), $urandom_range(0, 7), 2, 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 7), CL'($urandom));
        end

        // Reset on beat 2 of an N=3 run.
        start     = 1'b1;
        x_in      = 4'b0110;
        order_in  = 3'd3;
        out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_coeff", coeff_out, 0);
        chk("arst_data", data_out, 0);
        chk("arst_first_last", {out_first, out_last}, 0);
        for (int i = 0; i < NMAX; i++) mem_m[i] = '0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_done", done, 0);
        chk("post_rst_valid", out_valid, 0);
        run(4'b0101, 3, 0, 0, 0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
